// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's active-low CEN/WEN/OEN port.
// The array is zeroed after reset and can be preloaded on a side port.
// Define DMEM_ACCESS_COUNT_EN to build the saturating load/store counters.
module data_mem_responder #(
  parameter int unsigned AW    = 7,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          CEN,
  input  logic          WEN,
  input  logic          OEN,
  input  logic [AW-1:0] A,
  input  logic [DW-1:0] Data2Mem,
  output logic [DW-1:0] ReadDataMem,
  output logic          mem_ready,
  input  logic          init_valid,
  output logic          init_ready,
  input  logic [AW-1:0] init_addr,
  input  logic [DW-1:0] init_data,
  output logic          err_flag,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          state_q;
  logic [IW-1:0]   clr_ptr_q;
  logic            mem_ready_q;
  logic            err_q;
  logic [DW-1:0]   last_rdata_q;
  logic [DW-1:0]   mem_q [DEPTH];

  logic            run;
  logic            core_sel, is_load, is_store, is_illegal;
  logic            a_ok, ia_ok, ld_ok, st_ok, init_acc, err_set;
  logic [IW-1:0]   a_idx, ia_idx;
  logic [DW-1:0]   rdata_mem;
  logic            mem_we;
  logic [IW-1:0]   mem_waddr;
  logic [DW-1:0]   mem_wdata;

  assign run        = (state_q == StRun);
  assign a_idx      = A[IW-1:0];
  assign ia_idx     = init_addr[IW-1:0];
  assign a_ok       = (32'(A) < DEPTH);
  assign ia_ok      = (32'(init_addr) < DEPTH);

  assign core_sel   = run & ~CEN;
  assign is_illegal = core_sel & ~OEN & ~WEN;
  assign is_load    = core_sel & ~OEN & WEN;
  assign is_store   = core_sel & OEN & ~WEN;
  assign ld_ok      = is_load & a_ok;
  assign st_ok      = is_store & a_ok;

  // The core always wins: preload is only offered while the core is idle.
  assign init_ready = run & CEN;
  assign init_acc   = init_valid & init_ready;

  assign err_set    = is_illegal | ((is_load | is_store) & ~a_ok) | (init_acc & ~ia_ok);
  assign rdata_mem  = mem_q[a_idx];

  always_comb begin
    ReadDataMem = last_rdata_q;
    if (!run || is_illegal || (is_load && !a_ok)) begin
      ReadDataMem = '0;
    end else if (ld_ok) begin
      ReadDataMem = rdata_mem;
    end
  end

  // One write port shared by clear sweep, core stores and preload writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_ptr_q;
    mem_wdata = '0;
    if (!run) begin
      mem_we = 1'b1;
    end else if (st_ok) begin
      mem_we    = 1'b1;
      mem_waddr = a_idx;
      mem_wdata = Data2Mem;
    end else if (init_acc && ia_ok) begin
      mem_we    = 1'b1;
      mem_waddr = ia_idx;
      mem_wdata = init_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StClear;
      clr_ptr_q    <= '0;
      mem_ready_q  <= 1'b0;
      err_q        <= 1'b0;
      last_rdata_q <= '0;
    end else begin
      unique case (state_q)
        StClear: begin
          clr_ptr_q <= clr_ptr_q + 1'b1;
          if (32'(clr_ptr_q) == DEPTH - 1) begin
            state_q     <= StRun;
            mem_ready_q <= 1'b1;
          end
        end
        StRun: begin
          if (ld_ok) begin
            last_rdata_q <= rdata_mem;
          end
          if (err_set) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= StClear;
      endcase
    end
  end

  assign mem_ready = mem_ready_q;
  assign err_flag  = err_q;

`ifdef DMEM_ACCESS_COUNT_EN
  logic [15:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (ld_ok && (rd_cnt_q != 16'hFFFF)) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (st_ok && (wr_cnt_q != 16'hFFFF)) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule
